// File: rtl/spi_req_arbiter.sv
// spi_req_arbiter
// Round-robin arbiter sharing one SPI transaction engine between N packet
// requesters. One packet is forwarded at a time. The engine's ack and read
// byte are routed back to the granted requester. A timeout releases the
// engine if it never acknowledges. Every completion is followed by a fixed
// 2-cycle holdoff before the next grant.
module spi_req_arbiter #(
    parameter int N       = 2,
    parameter int TIMEOUT = 4096,
    parameter int TO_W    = 13
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [N-1:0]      req_i,
    input  logic [16*N-1:0]   pkt_i,
    output logic [N-1:0]      ack_o,
    output logic              err_o,
    output logic [7:0]        rdata_o,
    output logic              m_req_o,
    output logic [15:0]       m_pkt_o,
    input  logic              m_ack_i,
    input  logic [7:0]        m_rdata_i,
    output logic [1:0]        grant_o,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    logic [1:0]        last_q, last_d;
    logic [1:0]        grant_q, grant_d;
    logic              m_req_q, m_req_d;
    logic [15:0]       m_pkt_q, m_pkt_d;
    logic [N-1:0]      ack_q, ack_d;
    logic              err_q, err_d;
    logic [7:0]        rdata_q, rdata_d;
    logic              busy_q, busy_d;

    // Requests and packets padded to the 4-requester maximum, so a 2-bit
    // index can address them for any legal N.
    logic [3:0]        req_pad;
    logic [63:0]       pkt_pad;
    logic              sel_valid;
    logic [1:0]        sel_idx;
    logic [2:0]        cand_sum;
    logic [1:0]        cand;
    logic [N-1:0]      ack_onehot;
    logic [TO_W-1:0]   cnt_inc;

    // Zero-extend the request and packet buses to the padded width.
    always_comb begin
        req_pad          = 4'b0000;
        pkt_pad          = 64'h0;
        req_pad[N-1:0]   = req_i;
        pkt_pad[16*N-1:0] = pkt_i;
    end

    // Round-robin pick: scan last+1, last+2, ... modulo N and take the first
    // requester whose req is set.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = last_q;
        cand_sum  = 3'd0;
        cand      = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            if (i <= N) begin
                cand_sum = {1'b0, last_q} + 3'(i);
                // last < N and i <= N, so one subtraction wraps the sum.
                if (cand_sum >= 3'(N)) begin
                    cand_sum = cand_sum - 3'(N);
                end else begin
                    cand_sum = cand_sum;
                end
                cand = cand_sum[1:0];
                if (!sel_valid && req_pad[cand]) begin
                    sel_valid = 1'b1;
                    sel_idx   = cand;
                end else begin
                    sel_valid = sel_valid;
                end
            end else begin
                cand = cand;
            end
        end
    end

    // One-hot acknowledge vector for the requester currently granted.
    always_comb begin
        ack_onehot = '0;
        for (int k = 0; k < N; k++) begin
            ack_onehot[k] = (grant_q == 2'(k));
        end
    end

    // Next-state and registered-output logic of the arbitration FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        grant_d = grant_q;
        m_req_d = m_req_q;
        m_pkt_d = m_pkt_q;
        ack_d   = '0;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        cnt_inc = cnt_q + TO_W'(1);

        case (state_q)
            IDLE: begin
                if (sel_valid) begin
                    grant_d = sel_idx;
                    m_pkt_d = pkt_pad[{sel_idx, 4'b0000} +: 16];
                    m_req_d = 1'b1;
                    cnt_d   = '0;
                    state_d = BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                // The counter holds cycles spent in BUSY including this one,
                // so the abort lands on the edge TIMEOUT cycles after grant.
                cnt_d = cnt_inc;
                if (m_ack_i) begin
                    m_req_d = 1'b0;
                    m_pkt_d = 16'h0000;
                    ack_d   = ack_onehot;
                    rdata_d = m_rdata_i;
                    last_d  = grant_q;
                    cnt_d   = '0;
                    state_d = HOLDOFF;
                end else if (cnt_inc == TO_W'(TIMEOUT)) begin
                    m_req_d = 1'b0;
                    m_pkt_d = 16'h0000;
                    ack_d   = ack_onehot;
                    err_d   = 1'b1;
                    rdata_d = 8'h00;
                    last_d  = grant_q;
                    cnt_d   = '0;
                    state_d = HOLDOFF;
                end else begin
                    state_d = BUSY;
                end
            end
            HOLDOFF: begin
                // Two cycles, giving requesters time to drop req after ack.
                if (cnt_q == TO_W'(1)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d   = cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                m_req_d = 1'b0;
                m_pkt_d = 16'h0000;
            end
        endcase

        busy_d = (state_d == BUSY);
    end

    // State and output registers, cleared asynchronously by rst_i.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 2'(N - 1);
            grant_q <= 2'd0;
            m_req_q <= 1'b0;
            m_pkt_q <= 16'h0000;
            ack_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= 8'h00;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            m_req_q <= m_req_d;
            m_pkt_q <= m_pkt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
        end
    end

    assign ack_o   = ack_q;
    assign err_o   = err_q;
    assign rdata_o = rdata_q;
    assign m_req_o = m_req_q;
    assign m_pkt_o = m_pkt_q;
    assign grant_o = grant_q;
    assign busy_o  = busy_q;

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Testbench for spi_req_arbiter (N=2, TIMEOUT=16): directed scenarios plus
// randomized traffic checked against a transaction-level reference model.
module tb_spi_req_arbiter;

    localparam int N       = 2;
    localparam int TIMEOUT = 16;
    localparam int TO_W    = 5;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [N-1:0]      req_i;
    logic [16*N-1:0]   pkt_i;
    logic [N-1:0]      ack_o;
    logic              err_o;
    logic [7:0]        rdata_o;
    logic              m_req_o;
    logic [15:0]       m_pkt_o;
    logic              m_ack_i;
    logic [7:0]        m_rdata_i;
    logic [1:0]        grant_o;
    logic              busy_o;

    int n_cmp = 0;
    int n_err = 0;

    spi_req_arbiter #(.N(N), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .req_i    (req_i),
        .pkt_i    (pkt_i),
        .ack_o    (ack_o),
        .err_o    (err_o),
        .rdata_o  (rdata_o),
        .m_req_o  (m_req_o),
        .m_pkt_o  (m_pkt_o),
        .m_ack_i  (m_ack_i),
        .m_rdata_i(m_rdata_i),
        .grant_o  (grant_o),
        .busy_o   (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Reference round-robin rule: first requester after 'last', modulo N.
    function automatic int pick(input int last, input logic [N-1:0] r);
        for (int i = 1; i <= N; i++) begin
            int k;
            k = (last + i) % N;
            if (r[k]) return k;
        end
        return -1;
    endfunction

    task automatic do_reset();
        rst_i = 1'b1;
        req_i = '0;
        m_ack_i = 1'b0;
        step();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; req_i = '0; pkt_i = '0; m_ack_i = 1'b0; m_rdata_i = 8'h00;
        #3;
        n_cmp++; if (m_req_o !== 1'b0) begin n_err++; $display("FAIL reset_mreq: got %b want 0", m_req_o); end
        n_cmp++; if (m_pkt_o !== 16'h0000) begin n_err++; $display("FAIL reset_mpkt: got %h want 0000", m_pkt_o); end
        n_cmp++; if ({ack_o, err_o, rdata_o, grant_o, busy_o} !== 14'd0) begin
            n_err++; $display("FAIL reset_outs: ack=%b err=%b rdata=%h grant=%0d busy=%b want all 0", ack_o, err_o, rdata_o, grant_o, busy_o);
        end
        step(); step();
        rst_i = 1'b0;
        step();
        n_cmp++; if ({busy_o, m_req_o} !== 2'b00) begin n_err++; $display("FAIL reset_idle: busy=%b mreq=%b want 0 0", busy_o, m_req_o); end
    endtask

    task automatic test_single();
        pkt_i = '0; pkt_i[15:0] = 16'h310C; req_i = 2'b01;
        step();
        n_cmp++; if ({m_req_o, m_pkt_o} !== {1'b1, 16'h310C}) begin n_err++; $display("FAIL single_grant: mreq=%b mpkt=%h want 1 310c", m_req_o, m_pkt_o); end
        n_cmp++; if ({grant_o, busy_o} !== {2'd0, 1'b1}) begin n_err++; $display("FAIL single_grant_idx: grant=%0d busy=%b want 0 1", grant_o, busy_o); end
        for (int i = 1; i <= 4; i++) begin
            step();
            n_cmp++; if ({ack_o, m_req_o} !== {2'b00, 1'b1}) begin n_err++; $display("FAIL single_wait%0d: ack=%b mreq=%b want 00 1", i, ack_o, m_req_o); end
        end
        m_ack_i = 1'b1; m_rdata_i = 8'hE5;
        step();
        m_ack_i = 1'b0; m_rdata_i = 8'h00; req_i = 2'b00;
        n_cmp++; if ({ack_o, err_o, rdata_o} !== {2'b01, 1'b0, 8'hE5}) begin n_err++; $display("FAIL single_ack: ack=%b err=%b rdata=%h want 01 0 e5", ack_o, err_o, rdata_o); end
        n_cmp++; if ({m_req_o, m_pkt_o} !== 17'd0) begin n_err++; $display("FAIL single_release: mreq=%b mpkt=%h want 0 0000", m_req_o, m_pkt_o); end
        step();
        n_cmp++; if ({ack_o, rdata_o, busy_o} !== {2'b00, 8'hE5, 1'b0}) begin n_err++; $display("FAIL single_after: ack=%b rdata=%h busy=%b want 00 e5 0", ack_o, rdata_o, busy_o); end
        step();
    endtask

    task automatic test_simultaneous();
        int lows;
        int w;
        do_reset();
        pkt_i = {16'hA2B3, 16'h8101}; req_i = 2'b11;
        step();
        n_cmp++; if ({m_req_o, grant_o, m_pkt_o} !== {1'b1, 2'd0, 16'h8101}) begin n_err++; $display("FAIL simul_first: mreq=%b grant=%0d mpkt=%h want 1 0 8101", m_req_o, grant_o, m_pkt_o); end
        step();
        m_ack_i = 1'b1; m_rdata_i = 8'h5A;
        step();
        m_ack_i = 1'b0; req_i = 2'b10;
        n_cmp++; if (ack_o !== 2'b01) begin n_err++; $display("FAIL simul_ack0: got %b want 01", ack_o); end
        lows = 1; w = 0;
        while (!m_req_o && w < 12) begin
            step();
            if (!m_req_o) lows++;
            w++;
        end
        n_cmp++; if (m_req_o !== 1'b1) begin n_err++; $display("FAIL simul_second_timeout: mreq=%b want 1", m_req_o); end
        n_cmp++; if (lows != 3) begin n_err++; $display("FAIL simul_gap: got %0d low cycles want 3", lows); end
        n_cmp++; if ({grant_o, m_pkt_o} !== {2'd1, 16'hA2B3}) begin n_err++; $display("FAIL simul_second: grant=%0d mpkt=%h want 1 a2b3", grant_o, m_pkt_o); end
        m_ack_i = 1'b1; m_rdata_i = 8'h3C;
        step();
        m_ack_i = 1'b0; req_i = 2'b00;
        n_cmp++; if ({ack_o, rdata_o} !== {2'b10, 8'h3C}) begin n_err++; $display("FAIL simul_ack1: ack=%b rdata=%h want 10 3c", ack_o, rdata_o); end
        step(); step();
    endtask

    task automatic test_fairness();
        logic [15:0]  pk [N];
        logic [N-1:0] exp_ack;
        int prev;
        int expg;
        int d;
        int w;
        prev = -1; expg = 0;
        for (int k = 0; k < N; k++) begin
            pk[k] = 16'($urandom);
            pkt_i[16*k +: 16] = pk[k];
        end
        req_i = 2'b11;
        for (int t = 0; t < 8; t++) begin
            w = 0;
            while (!m_req_o && w < 12) begin step(); w++; end
            n_cmp++; if (m_req_o !== 1'b1) begin n_err++; $display("FAIL fair_wait%0d: mreq=%b want 1", t, m_req_o); end
            n_cmp++; if ({grant_o, m_pkt_o} !== {2'(expg), pk[expg]}) begin n_err++; $display("FAIL fair_grant%0d: grant=%0d mpkt=%h want %0d %h", t, grant_o, m_pkt_o, expg, pk[expg]); end
            n_cmp++; if (int'(grant_o) == prev) begin n_err++; $display("FAIL fair_repeat%0d: got %0d twice want alternation", t, grant_o); end
            prev = int'(grant_o);
            d = $urandom_range(1, 6);
            for (int i = 1; i < d; i++) step();
            m_ack_i = 1'b1; m_rdata_i = 8'($urandom_range(1, 255));
            step();
            m_ack_i = 1'b0;
            exp_ack = '0; exp_ack[expg] = 1'b1;
            n_cmp++; if (ack_o !== exp_ack) begin n_err++; $display("FAIL fair_ack%0d: got %b want %b", t, ack_o, exp_ack); end
            pk[expg] = 16'($urandom);
            pkt_i[16*expg +: 16] = pk[expg];
            expg = (expg + 1) % N;
        end
        req_i = 2'b00;
        step(); step();
    endtask

    task automatic test_timeout();
        pkt_i = '0; pkt_i[15:0] = 16'h9F00; req_i = 2'b01;
        step();
        n_cmp++; if ({m_req_o, grant_o} !== {1'b1, 2'd0}) begin n_err++; $display("FAIL to_grant: mreq=%b grant=%0d want 1 0", m_req_o, grant_o); end
        req_i = 2'b11; pkt_i[31:16] = 16'h2244;
        for (int j = 1; j <= TIMEOUT; j++) begin
            step();
            if (j < TIMEOUT) begin
                n_cmp++; if ({ack_o, err_o, m_req_o} !== {2'b00, 1'b0, 1'b1}) begin n_err++; $display("FAIL to_early%0d: ack=%b err=%b mreq=%b want 00 0 1", j, ack_o, err_o, m_req_o); end
            end
        end
        n_cmp++; if ({ack_o, err_o, rdata_o, m_req_o} !== {2'b01, 1'b1, 8'h00, 1'b0}) begin n_err++; $display("FAIL to_abort: ack=%b err=%b rdata=%h mreq=%b want 01 1 00 0", ack_o, err_o, rdata_o, m_req_o); end
        req_i = 2'b10;
        step();
        n_cmp++; if ({ack_o, err_o} !== 3'b000) begin n_err++; $display("FAIL to_pulse: ack=%b err=%b want 00 0", ack_o, err_o); end
        step(); step();
        n_cmp++; if ({m_req_o, grant_o, m_pkt_o} !== {1'b1, 2'd1, 16'h2244}) begin n_err++; $display("FAIL to_pending: mreq=%b grant=%0d mpkt=%h want 1 1 2244", m_req_o, grant_o, m_pkt_o); end
        m_ack_i = 1'b1; m_rdata_i = 8'h77;
        step();
        m_ack_i = 1'b0; req_i = 2'b00;
        n_cmp++; if ({ack_o, err_o, rdata_o} !== {2'b10, 1'b0, 8'h77}) begin n_err++; $display("FAIL to_next_ack: ack=%b err=%b rdata=%h want 10 0 77", ack_o, err_o, rdata_o); end
        step(); step();
    endtask

    task automatic test_collision();
        pkt_i = '0; pkt_i[15:0] = 16'h0A55; req_i = 2'b01;
        step();
        n_cmp++; if ({m_req_o, grant_o} !== {1'b1, 2'd0}) begin n_err++; $display("FAIL coll_grant: mreq=%b grant=%0d want 1 0", m_req_o, grant_o); end
        for (int i = 1; i < TIMEOUT; i++) step();
        m_ack_i = 1'b1; m_rdata_i = 8'hC3;
        step();
        req_i = 2'b00;
        n_cmp++; if ({ack_o, err_o, rdata_o} !== {2'b01, 1'b0, 8'hC3}) begin n_err++; $display("FAIL coll_ack: ack=%b err=%b rdata=%h want 01 0 c3", ack_o, err_o, rdata_o); end
        m_rdata_i = 8'h11;
        step();
        m_ack_i = 1'b0;
        n_cmp++; if ({ack_o, rdata_o} !== {2'b00, 8'hC3}) begin n_err++; $display("FAIL stray_holdoff: ack=%b rdata=%h want 00 c3", ack_o, rdata_o); end
        step(); step();
        m_ack_i = 1'b1; m_rdata_i = 8'h99;
        step();
        m_ack_i = 1'b0;
        n_cmp++; if ({ack_o, err_o, m_req_o, busy_o, rdata_o} !== {2'b00, 1'b0, 1'b0, 1'b0, 8'hC3}) begin n_err++; $display("FAIL stray_idle: ack=%b err=%b mreq=%b busy=%b rdata=%h want 00 0 0 0 c3", ack_o, err_o, m_req_o, busy_o, rdata_o); end
        step();
        n_cmp++; if (ack_o !== 2'b00) begin n_err++; $display("FAIL stray_late: ack=%b want 00", ack_o); end
    endtask

    task automatic test_reset_mid();
        pkt_i = {16'hBEEF, 16'h1234}; req_i = 2'b10;
        step();
        n_cmp++; if ({m_req_o, grant_o, busy_o} !== {1'b1, 2'd1, 1'b1}) begin n_err++; $display("FAIL rmid_grant: mreq=%b grant=%0d busy=%b want 1 1 1", m_req_o, grant_o, busy_o); end
        step(); step();
        #2;
        rst_i = 1'b1;
        #1;
        n_cmp++; if ({m_req_o, m_pkt_o, busy_o, grant_o} !== 20'd0) begin n_err++; $display("FAIL rmid_async: mreq=%b mpkt=%h busy=%b grant=%0d want 0", m_req_o, m_pkt_o, busy_o, grant_o); end
        n_cmp++; if ({ack_o, err_o, rdata_o} !== 11'd0) begin n_err++; $display("FAIL rmid_outs: ack=%b err=%b rdata=%h want 0", ack_o, err_o, rdata_o); end
        step();
        n_cmp++; if ({ack_o, m_req_o} !== 3'b000) begin n_err++; $display("FAIL rmid_held: ack=%b mreq=%b want 00 0", ack_o, m_req_o); end
        rst_i = 1'b0; req_i = 2'b11;
        step();
        n_cmp++; if ({m_req_o, grant_o, m_pkt_o, ack_o} !== {1'b1, 2'd0, 16'h1234, 2'b00}) begin n_err++; $display("FAIL rmid_prio: mreq=%b grant=%0d mpkt=%h ack=%b want 1 0 1234 00", m_req_o, grant_o, m_pkt_o, ack_o); end
        m_ack_i = 1'b1; m_rdata_i = 8'h42;
        step();
        m_ack_i = 1'b0; req_i = 2'b00;
        n_cmp++; if ({ack_o, rdata_o} !== {2'b01, 8'h42}) begin n_err++; $display("FAIL rmid_ack: ack=%b rdata=%h want 01 42", ack_o, rdata_o); end
        step(); step();
    endtask

    // Random requesters and engine latencies; the model tracks transactions
    // (who is granted, when it completes, what comes back), not DUT states.
    task automatic test_random();
        logic [15:0]  pk [N];
        logic [15:0]  cap_pkt;
        logic [N-1:0] rq;
        logic [N-1:0] exp_ack;
        logic [7:0]   dat;
        int  last_m, eg, j, d, eff, lows, cyc;
        bit  active;
        do_reset();
        last_m = N - 1; active = 1'b0; j = 0; d = 0; eff = 0; eg = 0;
        lows = 3; rq = '0; dat = 8'h00; cap_pkt = 16'h0000; cyc = 0;
        for (int k = 0; k < N; k++) pk[k] = 16'h0000;
        while (cyc < 1500 && (cyc < 905 || active || lows < 3)) begin
            step();
            cyc++;
            if (!active) begin
                if (m_req_o) begin
                    eg = pick(last_m, req_i);
                    cap_pkt = (eg >= 0) ? pkt_i[16*eg +: 16] : 16'h0000;
                    n_cmp++; if (grant_o !== 2'(eg)) begin n_err++; $display("FAIL rnd_grant@%0d: got %0d want %0d", cyc, grant_o, eg); end
                    n_cmp++; if (m_pkt_o !== cap_pkt) begin n_err++; $display("FAIL rnd_pkt@%0d: got %h want %h", cyc, m_pkt_o, cap_pkt); end
                    n_cmp++; if (lows < 3) begin n_err++; $display("FAIL rnd_gap@%0d: got %0d low cycles want >=3", cyc, lows); end
                    active = 1'b1; j = 0;
                    d = $urandom_range(1, TIMEOUT + 3);
                    eff = (d < TIMEOUT) ? d : TIMEOUT;
                    if (eg < 0) eg = 0;
                end else begin
                    n_cmp++;
                    if ((lows >= 3 && req_i != '0) || ack_o !== '0 || err_o !== 1'b0) begin
                        n_err++; $display("FAIL rnd_idle@%0d: mreq=%b ack=%b err=%b req=%b lows=%0d want grant or quiet", cyc, m_req_o, ack_o, err_o, req_i, lows);
                    end
                    lows++;
                end
            end else begin
                j++;
                if (j == eff) begin
                    exp_ack = '0; exp_ack[eg] = 1'b1;
                    n_cmp++;
                    if ({ack_o, err_o, rdata_o, m_req_o} !== {exp_ack, (d > TIMEOUT), ((d > TIMEOUT) ? 8'h00 : dat), 1'b0}) begin
                        n_err++; $display("FAIL rnd_done@%0d: ack=%b err=%b rdata=%h mreq=%b want %b %b %h 0", cyc, ack_o, err_o, rdata_o, m_req_o, exp_ack, (d > TIMEOUT), ((d > TIMEOUT) ? 8'h00 : dat));
                    end
                    active = 1'b0; last_m = eg; lows = 1; rq[eg] = 1'b0;
                end else begin
                    n_cmp++;
                    if ({ack_o, err_o, m_req_o, m_pkt_o} !== {2'b00, 1'b0, 1'b1, cap_pkt}) begin
                        n_err++; $display("FAIL rnd_busy@%0d: ack=%b err=%b mreq=%b mpkt=%h want 00 0 1 %h", cyc, ack_o, err_o, m_req_o, m_pkt_o, cap_pkt);
                    end
                end
            end
            m_ack_i = 1'b0;
            m_rdata_i = 8'($urandom);
            if (active && j + 1 == d) begin
                dat = 8'($urandom_range(1, 255));
                m_ack_i = 1'b1;
                m_rdata_i = dat;
            end else if (!active && $urandom_range(0, 7) == 0) begin
                m_ack_i = 1'b1;
            end
            for (int k = 0; k < N; k++) begin
                if (cyc >= 900) begin
                    rq[k] = 1'b0;
                end else if (active && k == eg) begin
                    if ($urandom_range(0, 3) == 0) pk[k] = 16'($urandom);
                    if ($urandom_range(0, 9) == 0) rq[k] = 1'b0;
                end else if (!rq[k] && !(lows == 1 && k == eg) && $urandom_range(0, 3) == 0) begin
                    rq[k] = 1'b1;
                    pk[k] = 16'($urandom);
                end
                pkt_i[16*k +: 16] = pk[k];
            end
            req_i = rq;
        end
        n_cmp++; if (active || cyc >= 1500) begin n_err++; $display("FAIL rnd_drain: active=%b cycles=%0d want drained", active, cyc); end
        req_i = '0; m_ack_i = 1'b0;
        step(); step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_timeout();
        test_collision();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/spi_req_arbiter.md
# spi_req_arbiter

Round-robin arbiter that shares the single SPI transaction engine between up to four packet requesters, such as the accelerometer init/readout sequencer and a debug/host register-access port. Each requester uses the same handshake the sequencer already drives: hold `req` high with a stable 16-bit packet until a one-cycle `ack`, then sample the returned byte. The arbiter forwards one granted packet at a time and routes the `ack` and read data back to that requester. A timeout releases the engine if it never acknowledges.

## Interface
- `N`, 2: number of requesters, legal range 2..4.
- `TIMEOUT`, 4096: maximum cycles in BUSY without `m_ack_i` before the transaction is aborted.
- `TO_W`, 13: width of the timeout counter; must satisfy 2^TO_W > TIMEOUT.

- `clk_i` in 1: the single clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `req_i` in N: per-requester request level.
- `pkt_i` in 16*N: requester k's packet on bits [16k+15:16k]; format {R/W, MB, addr[5:0], data[7:0]}.
- `ack_o` out N: one-cycle acknowledge to the granted requester.
- `err_o` out 1: one-cycle pulse, coincident with `ack_o`, when the transaction timed out.
- `rdata_o` out 8: returned byte; valid in the cycle `ack_o` is high, held afterwards.
- `m_req_o` out 1: request to the SPI engine.
- `m_pkt_o` out 16: packet to the SPI engine.
- `m_ack_i` in 1: one-cycle acknowledge from the SPI engine.
- `m_rdata_i` in 8: returned byte from the SPI engine, valid with `m_ack_i`.
- `grant_o` out 2: index of the current or last granted requester.
- `busy_o` out 1: high while in BUSY.

## Operation
- States:
  - IDLE: waiting for a request.
  - BUSY: a transaction is outstanding on the SPI engine.
  - HOLDOFF: a fixed 2-cycle gap after every completion.
- `last` pointer, N-index wide. Priority order is `last`+1, `last`+2, … modulo N.
- IDLE:
  - If any `req_i` bit is high, select the first set bit in priority order.
  - Register `grant_o`, copy that requester's `pkt_i` slice into `m_pkt_o`, set `m_req_o`=1, clear the timeout counter, and go to BUSY.
- BUSY:
  - `m_req_o` and `m_pkt_o` are held stable. Changes on `pkt_i` or `req_i` are ignored, including the granted requester dropping `req_i` early.
  - The timeout counter increments once per cycle.
  - On `m_ack_i`=1:
    - `m_req_o`←0, `m_pkt_o`←0.
    - `ack_o[grant]`←1 for exactly 1 cycle.
    - `rdata_o`←`m_rdata_i`.
    - `last`←`grant`.
    - Go to HOLDOFF.
  - On counter == TIMEOUT with `m_ack_i`=0: same as the ack case, except `rdata_o`←8'h00 and `err_o`←1 for 1 cycle.
  - If `m_ack_i` arrives in the same cycle as the timeout, the ack wins and `err_o` stays 0.
- HOLDOFF:
  - Lasts exactly 2 cycles with all requests ignored. This covers the requester deasserting `req` one edge after it sees `ack`.
  - Then go to IDLE.
- Ungranted requesters receive no `ack_o` and wait. This gives starvation-free round robin: under continuous requests from all N, each is served once per N transactions.
- `m_ack_i` outside BUSY is ignored.
- Reset values (asynchronous, immediate):
  - State IDLE.
  - `m_req_o`=0, `m_pkt_o`=0, `ack_o`=0, `err_o`=0, `rdata_o`=0, `grant_o`=0, `busy_o`=0.
  - Counter 0.
  - `last`=N-1, so requester 0 has top priority after reset.
- Reset asserted in BUSY drops `m_req_o` immediately. The SPI engine shares `rst_i` and aborts with it. No `ack_o` is issued for the aborted transaction.

## Timing
- All outputs are registered.
- Request latency: `req_i` high at edge E0 while IDLE gives `m_req_o`=1 and `m_pkt_o` valid after E0, i.e. 1 cycle.
- Completion: `m_ack_i` sampled at edge E1 gives `ack_o`, `rdata_o` and `m_req_o`=0 after E1, i.e. 1 cycle.
- Back-to-back: the next grant is registered no earlier than E1+3, so the minimum gap between two `m_req_o` pulses is 3 low cycles.
- Timeout: `m_req_o` rises at E0. With no ack, `ack_o` and `err_o` pulse in the cycle after edge E0+TIMEOUT.
- `busy_o` equals (state==BUSY), registered.

## Test plan
- **Single requester, N=2.** Stimulus: `req_i`=2'b01 with `pkt_i[15:0]`=16'h31_0C; SPI model acks 5 cycles later with data 8'hE5. Required: `m_pkt_o`=16'h310C one cycle after `req_i`; `ack_o`=2'b01 for exactly 1 cycle; `rdata_o`=8'hE5; `err_o`=0.
- **Simultaneous requests after reset.** Stimulus: both requesters request in the same cycle. Required: requester 0 is granted first, then requester 1 after HOLDOFF; `grant_o` sequence 0,1; `m_req_o` low for exactly 3 cycles between the two transactions.
- **Fairness.** Stimulus: both requesters hold requests continuously for 8 transactions. Required: grants alternate 0,1,0,1…; no requester is served twice in a row.
- **Timeout.** Stimulus: `TIMEOUT`=16 and the SPI model never acks. Required: `ack_o` and `err_o` pulse together 16 cycles after `m_req_o` rises; `rdata_o`=8'h00; `m_req_o` falls; a pending request is then granted.
- **Ack/timeout collision and stray ack.** Stimulus: ack exactly at cycle TIMEOUT, plus an `m_ack_i` pulse while IDLE. Required: the collision returns the engine's data with `err_o`=0; the stray ack produces no `ack_o`.
- **Reset mid-transaction.** Stimulus: assert `rst_i` while in BUSY. Required: `m_req_o` and every other output are 0 asynchronously; no `ack_o` is issued; after release, requester 0 has priority.
